// File: rtl/pcnt_pkg.sv
// pcnt_pkg: pin map, mode encodings and status byte layout for the parametrised counter
package pcnt_pkg;
  localparam int CLR = 0;
  localparam int DIR = 1;
  localparam int LOAD = 2;
  localparam int MODE = 3;
  localparam int PSEL_LSB = 4;
  localparam int PSEL_MSB = 6;
  localparam int VIEW = 7;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT = 1'b1;
  localparam int STATUS_STICKY = 7;
  localparam int STATUS_FLAG = 6;
  localparam int STATUS_MAX = 5;
  localparam int STATUS_MIN = 4;
  localparam int STATUS_MODE = 3;
  localparam int STATUS_PSEL_MSB = 2;
  localparam int STATUS_PSEL_LSB = 0;
endpackage

// File: rtl/tt_um_pcnt_prescaler.sv
// tt_um_pcnt_prescaler: power-of-two divider producing a one-cycle tick every 2**sel enabled cycles
module tt_um_pcnt_prescaler #(
  parameter int PRESC_W = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [2:0] sel,
  output logic       tick
);
  logic [PRESC_W-1:0] cnt_q, cnt_d, term;
  // >= rather than == so lowering sel mid-period ticks immediately
  always_comb begin
    term = ~({PRESC_W{1'b1}} << sel);
    tick = cnt_q >= term;
    cnt_d = !en ? cnt_q : (clr || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/tt_um_param_counter.sv
// tt_um_param_counter: up/down counter with load, wrap/saturate, prescaler, modulo limit and terminal flags
module tt_um_param_counter #(
  parameter int WIDTH = 8,
  parameter int MAX_COUNT = 2**WIDTH - 1,
  parameter int PRESC_W = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  import pcnt_pkg::*;
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);
  logic [WIDTH-1:0] cnt_q, cnt_d, nxt, ld_val;
  logic flag_q, flag_d, sticky_q, sticky_d;
  logic clr, dir, load, mode, view, tick, at_max, at_min, term_ev;
  logic [2:0] psel;
  logic [7:0] status;
  logic unused_ok;
  assign clr = ui_in[CLR];
  assign dir = ui_in[DIR];
  assign load = ui_in[LOAD];
  assign mode = ui_in[MODE];
  assign psel = ui_in[PSEL_MSB:PSEL_LSB];
  assign view = ui_in[VIEW];
  assign uio_out = 8'h00;
  assign uio_oe = 8'h00;
  assign unused_ok = &{1'b0, uio_in};
  tt_um_pcnt_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (ena),
    .clr  (clr || load),
    .sel  (psel),
    .tick (tick)
  );
  always_comb begin
    at_max = cnt_q == MAXV;
    at_min = cnt_q == '0;
    ld_val = uio_in[WIDTH-1:0] > MAXV ? MAXV : uio_in[WIDTH-1:0];
    nxt = dir ? (at_max ? (mode == MODE_SAT ? cnt_q : '0) : cnt_q + 1'b1)
              : (at_min ? (mode == MODE_SAT ? cnt_q : MAXV) : cnt_q - 1'b1);
    term_ev = !clr && !load && tick && (dir ? at_max : at_min);
    cnt_d = !ena ? cnt_q : clr ? '0 : load ? ld_val : tick ? nxt : cnt_q;
    flag_d = !ena ? flag_q : term_ev;
    sticky_d = !ena ? sticky_q : clr ? 1'b0 : sticky_q | term_ev;
    status = 8'h00;
    status[STATUS_STICKY] = sticky_q;
    status[STATUS_FLAG] = flag_q;
    status[STATUS_MAX] = at_max;
    status[STATUS_MIN] = at_min;
    status[STATUS_MODE] = mode;
    status[STATUS_PSEL_MSB:STATUS_PSEL_LSB] = psel;
    uo_out = view ? status : 8'(cnt_q);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      flag_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      flag_q <= flag_d;
      sticky_q <= sticky_d;
    end
endmodule
